// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divide controller and its result cache.
package div_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_RESP  = 2'b11
    } div_state_e;

    localparam logic [XLEN-1:0] DIV_BY_ZERO_QUOT = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT32_MIN        = 32'h8000_0000;

endpackage

// File: rtl/div_result_cache.sv
// One-entry cache of the last divider result, keyed on operands and signedness.
module div_result_cache
    import div_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            wr_en_i,
    input  logic [XLEN-1:0] wr_dividend_i,
    input  logic [XLEN-1:0] wr_divisor_i,
    input  logic            wr_signed_i,
    input  logic [XLEN-1:0] wr_quot_i,
    input  logic [XLEN-1:0] wr_rem_i,
    input  logic [XLEN-1:0] rd_dividend_i,
    input  logic [XLEN-1:0] rd_divisor_i,
    input  logic            rd_signed_i,
    output logic            hit_c,
    output logic [XLEN-1:0] quot_o,
    output logic [XLEN-1:0] rem_o
);

    logic            r_valid;
    logic [XLEN-1:0] r_dividend;
    logic [XLEN-1:0] r_divisor;
    logic            r_signed;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_rem;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid    <= 1'b0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_signed   <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
        end else if (wr_en_i) begin
            r_valid    <= 1'b1;
            r_dividend <= wr_dividend_i;
            r_divisor  <= wr_divisor_i;
            r_signed   <= wr_signed_i;
            r_quot     <= wr_quot_i;
            r_rem      <= wr_rem_i;
        end
    end

    assign hit_c  = r_valid && (r_dividend == rd_dividend_i) &&
                    (r_divisor == rd_divisor_i) && (r_signed == rd_signed_i);
    assign quot_o = r_quot;
    assign rem_o  = r_rem;

endmodule

// File: rtl/div_controller.sv
// Sequences DIV/DIVU/REM/REMU requests onto the shared iterative divider, resolving
// RISC-V special cases and repeated operands without a divider run.
module div_controller
    import div_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stb_i,
    input  logic            cyc_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] result_o,
    output logic            ack_o,
    output logic            div_stb_o,
    output logic            div_cyc_o,
    output logic [XLEN-1:0] div_dividend_o,
    output logic [XLEN-1:0] div_divisor_o,
    output logic            div_is_signed_o,
    input  logic [XLEN-1:0] div_quot_i,
    input  logic [XLEN-1:0] div_rem_i,
    input  logic            div_ack_i
);

    div_state_e      r_state;
    logic            r_ack_q;
    logic            r_div_stb;
    logic            r_div_signed;
    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] r_div_dividend;
    logic [XLEN-1:0] r_div_divisor;

    div_op_e         w_op;
    logic            w_is_signed;
    logic            w_sel_rem;
    logic            w_div_by_zero;
    logic            w_overflow;
    logic            w_cache_hit;
    logic            w_cache_wr;
    logic [XLEN-1:0] w_cache_quot;
    logic [XLEN-1:0] w_cache_rem;

    assign w_op          = div_op_e'(op_i);
    assign w_is_signed   = (w_op == OP_DIV) || (w_op == OP_REM);
    assign w_sel_rem     = (w_op == OP_REM) || (w_op == OP_REMU);
    assign w_div_by_zero = (divisor_i == '0);
    assign w_overflow    = w_is_signed && (dividend_i == INT32_MIN) && (divisor_i == '1);
    assign w_cache_wr    = (r_state == ST_RUN) && div_ack_i;

    div_result_cache u_cache (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .wr_en_i       (w_cache_wr),
        .wr_dividend_i (r_div_dividend),
        .wr_divisor_i  (r_div_divisor),
        .wr_signed_i   (r_div_signed),
        .wr_quot_i     (div_quot_i),
        .wr_rem_i      (div_rem_i),
        .rd_dividend_i (dividend_i),
        .rd_divisor_i  (divisor_i),
        .rd_signed_i   (w_is_signed),
        .hit_c         (w_cache_hit),
        .quot_o        (w_cache_quot),
        .rem_o         (w_cache_rem)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= ST_IDLE;
            r_ack_q        <= 1'b0;
            r_div_stb      <= 1'b0;
            r_div_signed   <= 1'b0;
            r_result       <= '0;
            r_div_dividend <= '0;
            r_div_divisor  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (stb_i && cyc_i && !r_ack_q) begin
                        if (w_div_by_zero) begin
                            r_result <= w_sel_rem ? dividend_i : DIV_BY_ZERO_QUOT;
                            r_state  <= ST_RESP;
                        end else if (w_overflow) begin
                            r_result <= w_sel_rem ? '0 : INT32_MIN;
                            r_state  <= ST_RESP;
                        end else if (w_cache_hit) begin
                            r_result <= w_sel_rem ? w_cache_rem : w_cache_quot;
                            r_state  <= ST_RESP;
                        end else begin
                            r_div_dividend <= dividend_i;
                            r_div_divisor  <= divisor_i;
                            r_div_signed   <= w_is_signed;
                            r_div_stb      <= 1'b1;
                            r_state        <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // A request withdrawn in the ack cycle is an abort; the cache still fills.
                    if (div_ack_i) begin
                        r_div_stb <= 1'b0;
                        if (stb_i) begin
                            r_result <= w_sel_rem ? div_rem_i : div_quot_i;
                            r_state  <= ST_RESP;
                        end else begin
                            r_state  <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_IDLE;
                end
                ST_RESP: begin
                    if (!r_ack_q) begin
                        r_ack_q <= 1'b1;
                    end else if (!stb_i) begin
                        r_ack_q <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack_o           = r_ack_q & stb_i;
    assign result_o        = r_result;
    assign div_stb_o       = r_div_stb;
    assign div_cyc_o       = r_div_stb;
    assign div_dividend_o  = r_div_dividend;
    assign div_divisor_o   = r_div_divisor;
    assign div_is_signed_o = r_div_signed;

endmodule

// File: tb/tb_div_controller.sv
// Randomized bench for div_controller: an RV32M arithmetic model plus a result-cache
// model predict every cycle's outputs; a responder plays the shared divider.
module tb_div_controller;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stb_i, cyc_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i, divisor_i;
    logic [31:0] result_o;
    logic        ack_o, div_stb_o, div_cyc_o, div_is_signed_o;
    logic [31:0] div_dividend_o, div_divisor_o;
    logic [31:0] div_quot_i, div_rem_i;
    logic        div_ack_i;

    div_controller dut (
        .clk_i(clk_i), .rst_i(rst_i), .stb_i(stb_i), .cyc_i(cyc_i), .op_i(op_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .result_o(result_o),
        .ack_o(ack_o), .div_stb_o(div_stb_o), .div_cyc_o(div_cyc_o),
        .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
        .div_is_signed_o(div_is_signed_o), .div_quot_i(div_quot_i),
        .div_rem_i(div_rem_i), .div_ack_i(div_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int          n_vec = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;
    logic        exp_ack = 1'b0;
    logic [31:0] exp_result = '0;
    logic        exp_div_stb = 1'b0;
    logic [31:0] exp_a = '0, exp_b = '0;
    logic        exp_sgn = 1'b0;

    // Cache model: the last completed divider run
    bit          c_valid = 1'b0;
    logic [31:0] c_a = '0, c_b = '0;
    logic        c_sgn = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // RV32M semantics returned as {quotient, remainder}
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
        if (sgn) begin
            sa = int'(a);
            sb = int'(b);
            return {32'(sa / sb), 32'(sa % sb)};
        end
        return {a / b, a % b};
    endfunction

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("ack_o", 32'(ack_o), 32'(exp_ack));
            if (exp_ack) check("result_o", result_o, exp_result);
            check("div_stb_o", 32'(div_stb_o), 32'(exp_div_stb));
            check("div_cyc_o", 32'(div_cyc_o), 32'(exp_div_stb));
            if (exp_div_stb) begin
                check("div_dividend_o", div_dividend_o, exp_a);
                check("div_divisor_o", div_divisor_o, exp_b);
                check("div_is_signed_o", 32'(div_is_signed_o), 32'(exp_sgn));
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One request; abort_at in [0, lat] withdraws stb during the divider run
    task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int abort_at, input bit has_lit, input logic [31:0] lit);
        logic        sgn;
        logic [63:0] qr;
        logic [31:0] res;
        bit          fast, aborted;
        sgn     = ~op[0];
        qr      = ref_div(sgn, a, b);
        res     = op[1] ? qr[31:0] : qr[63:32];
        fast    = (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
                  (c_valid && c_a == a && c_b == b && c_sgn == sgn);
        aborted = 1'b0;
        stb_i = 1'b1; cyc_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b;
        step();
        if (!fast) begin
            exp_div_stb = 1'b1; exp_a = a; exp_b = b; exp_sgn = sgn;
            for (int i = 0; i < lat; i++) begin
                if (i == abort_at) begin stb_i = 1'b0; cyc_i = 1'b0; aborted = 1'b1; end
                step();
            end
            if (abort_at == lat) begin stb_i = 1'b0; cyc_i = 1'b0; aborted = 1'b1; end
            div_ack_i = 1'b1; div_quot_i = qr[63:32]; div_rem_i = qr[31:0];
            step();
            div_ack_i = 1'b0; div_quot_i = $urandom; div_rem_i = $urandom;
            exp_div_stb = 1'b0;
            c_valid = 1'b1; c_a = a; c_b = b; c_sgn = sgn;
        end
        if (aborted) begin
            step();
        end else begin
            step();
            exp_ack = 1'b1; exp_result = res;
            if (has_lit) check("directed_result", result_o, lit);
            step();
            stb_i = 1'b0; cyc_i = 1'b0; exp_ack = 1'b0;
            step();
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_result", result_o, 32'd0);
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_div_stb", 32'(div_stb_o), 32'd0);
        check("rst_div_cyc", 32'(div_cyc_o), 32'd0);
        check("rst_div_dividend", div_dividend_o, 32'd0);
        check("rst_div_divisor", div_divisor_o, 32'd0);
        check("rst_div_signed", 32'(div_is_signed_o), 32'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [1:0]  op;
        rst_i = 1'b1; stb_i = 1'b0; cyc_i = 1'b0; op_i = '0;
        dividend_i = '0; divisor_i = '0; div_quot_i = '0; div_rem_i = '0; div_ack_i = 1'b0;
        step(); step();
        check_reset_outputs();
        rst_i = 1'b0;
        step();
        chk_en = 1'b1;

        do_req(OP_DIV,  32'd100, 32'd7, 33, -1, 1'b1, 32'd14);
        do_req(OP_REM,  32'd100, 32'd7, 33, -1, 1'b1, 32'd2);
        do_req(OP_DIV,  32'hFFFF_FFF9, 32'd2, 33, -1, 1'b1, 32'hFFFF_FFFD);
        do_req(OP_REM,  32'hFFFF_FFF9, 32'd2, 33, -1, 1'b1, 32'hFFFF_FFFF);
        do_req(OP_REMU, 32'hFFFF_FFF9, 32'd2, 33, -1, 1'b1, 32'd1);
        do_req(OP_DIVU, 32'd5, 32'd0, 33, -1, 1'b1, 32'hFFFF_FFFF);
        do_req(OP_REM,  32'd5, 32'd0, 33, -1, 1'b1, 32'd5);
        do_req(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 33, -1, 1'b1, 32'h8000_0000);
        do_req(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 33, -1, 1'b1, 32'd0);
        do_req(OP_DIV,  32'd1000, 32'd3, 33, 10, 1'b0, 32'd0);
        do_req(OP_REM,  32'd1000, 32'd3, 33, -1, 1'b1, 32'd1);

        // Reset in the middle of a divider run
        stb_i = 1'b1; cyc_i = 1'b1; op_i = OP_DIV; dividend_i = 32'd2000; divisor_i = 32'd7;
        step();
        exp_div_stb = 1'b1; exp_a = 32'd2000; exp_b = 32'd7; exp_sgn = 1'b1;
        repeat (5) step();
        rst_i = 1'b1; stb_i = 1'b0; cyc_i = 1'b0; exp_div_stb = 1'b0;
        #1;
        check_reset_outputs();
        c_valid = 1'b0;
        step();
        rst_i = 1'b0;
        step();
        do_req(OP_DIV, 32'd1000, 32'd3, 33, -1, 1'b1, 32'd333);
        do_req(OP_DIV, 32'd9, 32'd3, 33, -1, 1'b1, 32'd3);

        // Random traffic biased towards special operands and repeats for cache hits
        a = 32'd1; b = 32'd1;
        for (int t = 0; t < 120; t++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) >= 3) begin
                case ($urandom_range(0, 5))
                    0: a = 32'd0;
                    1: a = 32'h8000_0000;
                    2: a = 32'hFFFF_FFFF;
                    3: a = 32'($urandom_range(0, 20));
                    default: a = $urandom;
                endcase
                case ($urandom_range(0, 5))
                    0: b = 32'd0;
                    1: b = 32'hFFFF_FFFF;
                    2: b = 32'($urandom_range(1, 9));
                    3: b = 32'h8000_0000;
                    default: b = $urandom;
                endcase
            end
            do_req(op, a, b, int'($urandom_range(1, 34)),
                   ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 35)) : -1, 1'b0, 32'd0);
            if ($urandom_range(0, 3) == 0) step();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_controller.md
# div_controller

Sequencing controller that sits between the RV32M execute stage and the shared iterative `divider`. It decodes DIV/DIVU/REM/REMU requests and resolves RISC-V special cases (divide-by-zero, signed overflow) without starting the divider. It keeps a one-entry result cache, so a DIV/REM pair on identical operands costs one divider run. When the requester withdraws mid-division, it completes the divider handshake safely.

## Interface
- No parameters.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `stb_i` in 1: request strobe; held until `ack_o`, then dropped for ≥1 cycle.
- `cyc_i` in 1: request cycle; qualifies `stb_i`.
- `op_i` in 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU; stable while `stb_i`.
- `dividend_i` in 32: rs1 value.
- `divisor_i` in 32: rs2 value.
- `result_o` out 32: selected quotient or remainder; valid while `ack_o`.
- `ack_o` out 1: `ack_q & stb_i`.
- `div_stb_o`, `div_cyc_o` out 1: divider strobe/cycle (identical).
- `div_dividend_o`, `div_divisor_o` out 32: registered operands.
- `div_is_signed_o` out 1: registered signedness.
- `div_quot_i`, `div_rem_i` in 32: divider results.
- `div_ack_i` in 1: divider acknowledge.

## Operation
- States: IDLE, RUN, DRAIN, RESP.
- IDLE, on `stb_i & cyc_i & ~ack_q`, classify the request, priority order:
  - **Zero divisor.** Quotient = 0xFFFFFFFF for both DIV and DIVU; remainder = `dividend_i`. Go to RESP.
  - **Overflow.** Signed op with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient 0x80000000, remainder 0. Go to RESP.
  - **Cache hit.** `cache_valid` set and dividend, divisor and signedness all equal the cached entry: return the cached quotient/remainder. Go to RESP.
  - **Otherwise.** Latch operands; set `div_is_signed_o = ~op_i[0]`; assert `div_stb_o`; go to RUN.
- RUN: hold `div_stb_o` and operands until `div_ack_i`.
  - On ack: write the cache (operands, signedness, `div_quot_i`, `div_rem_i`, valid=1) and deassert `div_stb_o`.
  - If `stb_i` is still high, go to RESP with the result selected by `op_i[1]`.
  - If `stb_i` dropped during RUN (abort), go to DRAIN with no ack; the cache is still written.
- DRAIN: one cycle with `div_stb_o` low, so the divider's internal ack clears. Then go to IDLE.
- RESP: `ack_q`=1; stay until `stb_i` low, then clear `ack_q` and go to IDLE.
- Special-case results never write the cache; the cache is never invalidated except by reset.
- Result selection: `op_i[1]`=0 gives the quotient, 1 gives the remainder.

## Timing
- Reset values (async): state IDLE; `ack_q`, `div_stb_o`, `div_cyc_o`, `div_is_signed_o`, `cache_valid` all 0; `result_o`, `div_dividend_o`, `div_divisor_o` all 0.
- Fast path (special case or hit): request sampled in IDLE at edge N; `ack_o` high after edge N+1.
- Divider path: `div_stb_o` high after edge N+1; `ack_o` high one cycle after `div_ack_i` is sampled. Total is about 36 cycles.
- `div_stb_o` is always low for ≥1 cycle between two divider transactions; DRAIN or RESP guarantees this.
- Simultaneous `div_ack_i` and `stb_i` falling: treated as an abort; cache written, no ack.
- Reset mid-RUN: controller returns to IDLE immediately and drops `div_stb_o`. The divider, which shares `rst_i`, also resets.
- `ack_o` falls combinationally with `stb_i`.

## Structure
- `div_pkg`:
  - `div_op_e` (DIV, DIVU, REM, REMU).
  - `div_state_e`.
  - Constants `DIV_BY_ZERO_QUOT` = 32'hFFFFFFFF and `INT32_MIN` = 32'h80000000.
- One sub-module, `div_result_cache`:
  - Single entry: valid flag, operands, signedness, quotient, remainder.
  - Combinational hit compare and registered write port.
- Special-case decode stays inline.

## Test plan
- DIV 100 / 7 → `result_o` = 14 after ~36 cycles. Then REM 100 / 7 → 2, with `ack_o` one cycle after the request and `div_stb_o` never asserted.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. Then REM on the same operands → 0xFFFFFFFF (cache hit). Then REMU on the same operands → divider run, result 1.
- DIVU 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5; both in 1 cycle; `div_stb_o` stays 0.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM on the same operands → 0; no divider activity.
- DIV 1000 / 3, drop `stb_i` 10 cycles in:
  - no `ack_o` pulse; `div_stb_o` held until `div_ack_i`;
  - one DRAIN cycle;
  - a subsequent REM 1000 / 3 hits the cache → 1.
- Assert `rst_i` mid-RUN → all outputs 0 asynchronously, `cache_valid` 0. Next DIV 9 / 3 → 3 via a full divider run.
